// File: rtl/cprv_hazard_ctrl.sv
// Scoreboard-style RAW hazard control for an in-order pipeline.
// Each register has a saturating pending-write counter; decode stalls on RAW hits or a full counter.

module cprv_hazard_cnt #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // inc is never asserted at saturation and dec never at zero; the caller gates both.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)              cnt_d = '0;
    else if (inc_i && !dec_i) cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module cprv_hazard_ctrl #(
  parameter int NREG      = 32,
  parameter int CNT_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_use_i,
  input  logic       id_rs2_use_i,
  input  logic [4:0] id_rd_addr_i,
  input  logic       id_rd_en_i,
  input  logic       ex_ready_i,
  input  logic       wb_valid_i,
  input  logic [4:0] wb_rd_addr_i,
  input  logic       flush_i,
  output logic       id_ready_o,
  output logic       issue_fire_o,
  output logic       hazard_o,
  output logic [6:0] inflight_o,
  output logic       err_o
);
  localparam logic [CNT_WIDTH-1:0] SAT = {CNT_WIDTH{1'b1}};

  logic [NREG-1:0][CNT_WIDTH-1:0] pend;
  logic [NREG-1:0]                inc_vec, dec_vec;
  logic rs1_haz, rs2_haz, rd_sat;
  logic inc, wb_nz, dec, underflow;
  logic [6:0] inflight_q, inflight_d;
  logic       err_q, err_d;

  assign pend[0]    = '0;
  assign inc_vec[0] = 1'b0;
  assign dec_vec[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    assign inc_vec[r] = inc && (id_rd_addr_i == 5'(r));
    assign dec_vec[r] = dec && (wb_rd_addr_i == 5'(r));
    cprv_hazard_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_i),
      .inc_i   (inc_vec[r]),
      .dec_i   (dec_vec[r]),
      .cnt_o   (pend[r])
    );
  end

  // Registered counters only: a same-cycle retire does not unblock decode.
  always_comb begin
    rs1_haz      = id_rs1_use_i && (|id_rs1_addr_i) && (|pend[id_rs1_addr_i]);
    rs2_haz      = id_rs2_use_i && (|id_rs2_addr_i) && (|pend[id_rs2_addr_i]);
    rd_sat       = id_rd_en_i && (|id_rd_addr_i) && (pend[id_rd_addr_i] == SAT);
    hazard_o     = id_valid_i && (rs1_haz || rs2_haz || rd_sat);
    id_ready_o   = !hazard_o && ex_ready_i;
    issue_fire_o = id_valid_i && id_ready_o;
    inc          = issue_fire_o && id_rd_en_i && (|id_rd_addr_i);
    wb_nz        = wb_valid_i && (|wb_rd_addr_i);
    dec          = wb_nz && (|pend[wb_rd_addr_i]);
    underflow    = wb_nz && !(|pend[wb_rd_addr_i]);
  end

  always_comb begin
    err_d      = err_q || underflow;
    inflight_d = inflight_q + 7'(inc) - 7'(dec);
    if (flush_i) inflight_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight_o = inflight_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_cprv_hazard_ctrl.sv
// Directed bench for cprv_hazard_ctrl: inputs change 1ns after a rising edge, checks 1ns later.

module tb_cprv_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, wb_rd_addr_i;
  logic       id_rs1_use_i, id_rs2_use_i, id_rd_en_i;
  logic       ex_ready_i, wb_valid_i, flush_i;
  logic       id_ready_o, issue_fire_o, hazard_o, err_o;
  logic [6:0] inflight_o;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cprv_hazard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid_i    (id_valid_i),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_use_i  (id_rs1_use_i),
    .id_rs2_use_i  (id_rs2_use_i),
    .id_rd_addr_i  (id_rd_addr_i),
    .id_rd_en_i    (id_rd_en_i),
    .ex_ready_i    (ex_ready_i),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .flush_i       (flush_i),
    .id_ready_o    (id_ready_o),
    .issue_fire_o  (issue_fire_o),
    .hazard_o      (hazard_o),
    .inflight_o    (inflight_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_valid_i = 0; id_rs1_use_i = 0; id_rs2_use_i = 0; id_rd_en_i = 0;
    id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
    wb_valid_i = 0; wb_rd_addr_i = 0; flush_i = 0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    id_valid_i = 1; id_rd_en_i = 1; id_rd_addr_i = rd;
    id_rs1_use_i = 0; id_rs2_use_i = 0;
  endtask

  initial begin
    rst_n = 0; ex_ready_i = 1; idle();
    #3;
    chk("rst_inflight", 32'(inflight_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_hazard", 32'(hazard_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    chk("post_rst_ready", 32'(id_ready_o), 32'd1);
    chk("post_rst_fire", 32'(issue_fire_o), 32'd0);
    ex_ready_i = 0; #1;
    chk("post_rst_ready_exlow", 32'(id_ready_o), 32'd0);

    cyc(); issue_wr(5'd5); #1;
    chk("exlow_fire", 32'(issue_fire_o), 32'd0);
    cyc();
    chk("exlow_inflight", 32'(inflight_o), 32'd0);

    ex_ready_i = 1; #1;
    chk("add_fire", 32'(issue_fire_o), 32'd1);
    cyc();
    chk("add_inflight", 32'(inflight_o), 32'd1);
    id_rd_en_i = 0; id_rs1_use_i = 1; id_rs1_addr_i = 5'd5; #1;
    chk("raw_hazard", 32'(hazard_o), 32'd1);
    chk("raw_ready", 32'(id_ready_o), 32'd0);
    chk("raw_fire", 32'(issue_fire_o), 32'd0);
    wb_valid_i = 1; wb_rd_addr_i = 5'd5; #1;
    chk("raw_no_bypass", 32'(hazard_o), 32'd1);
    cyc();
    wb_valid_i = 0; #1;
    chk("raw_resolved", 32'(hazard_o), 32'd0);
    chk("raw_fire_after_wb", 32'(issue_fire_o), 32'd1);
    chk("raw_inflight_after_wb", 32'(inflight_o), 32'd0);

    idle(); id_valid_i = 1; id_rs1_use_i = 1; id_rs2_use_i = 1; id_rd_en_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("x0_hazard", 32'(hazard_o), 32'd0);
      cyc();
      chk("x0_inflight", 32'(inflight_o), 32'd0);
    end

    idle(); issue_wr(5'd7);
    cyc(); cyc(); cyc();
    chk("sat_inflight3", 32'(inflight_o), 32'd3);
    chk("sat_hazard", 32'(hazard_o), 32'd1);
    chk("sat_ready", 32'(id_ready_o), 32'd0);
    wb_valid_i = 1; wb_rd_addr_i = 5'd7; #1;
    chk("sat_no_bypass", 32'(hazard_o), 32'd1);
    cyc();
    wb_valid_i = 0; #1;
    chk("sat_inflight2", 32'(inflight_o), 32'd2);
    chk("sat_fourth_fire", 32'(issue_fire_o), 32'd1);
    cyc();
    chk("sat_inflight_back3", 32'(inflight_o), 32'd3);
    idle(); wb_valid_i = 1; wb_rd_addr_i = 5'd7;
    cyc(); cyc(); cyc();
    chk("sat_drained", 32'(inflight_o), 32'd0);
    chk("sat_no_err", 32'(err_o), 32'd0);

    idle(); issue_wr(5'd3);
    cyc();
    chk("x3_inflight1", 32'(inflight_o), 32'd1);
    wb_valid_i = 1; wb_rd_addr_i = 5'd3; #1;
    chk("x3_fire", 32'(issue_fire_o), 32'd1);
    cyc();
    chk("x3_inflight_same", 32'(inflight_o), 32'd1);
    idle(); id_valid_i = 1; id_rs1_use_i = 1; id_rs1_addr_i = 5'd3; #1;
    chk("x3_still_pending", 32'(hazard_o), 32'd1);
    idle(); wb_valid_i = 1; wb_rd_addr_i = 5'd3;
    cyc();
    chk("x3_drained", 32'(inflight_o), 32'd0);

    idle(); wb_valid_i = 1; wb_rd_addr_i = 5'd0;
    cyc();
    chk("wb_x0_no_err", 32'(err_o), 32'd0);
    wb_rd_addr_i = 5'd9;
    cyc();
    wb_valid_i = 0;
    chk("underflow_err", 32'(err_o), 32'd1);
    chk("underflow_inflight", 32'(inflight_o), 32'd0);

    issue_wr(5'd1); cyc();
    issue_wr(5'd2); cyc();
    issue_wr(5'd4); cyc();
    issue_wr(5'd8); cyc();
    chk("pre_flush_inflight", 32'(inflight_o), 32'd4);
    issue_wr(5'd10); wb_valid_i = 1; wb_rd_addr_i = 5'd1; flush_i = 1;
    cyc();
    idle();
    chk("flush_inflight", 32'(inflight_o), 32'd0);
    chk("flush_keeps_err", 32'(err_o), 32'd1);
    id_valid_i = 1; id_rs1_use_i = 1; id_rs1_addr_i = 5'd1;
    id_rs2_use_i = 1; id_rs2_addr_i = 5'd10; id_rd_en_i = 1; id_rd_addr_i = 5'd2; #1;
    chk("flush_no_hazard", 32'(hazard_o), 32'd0);
    cyc();
    chk("post_flush_inflight", 32'(inflight_o), 32'd1);
    id_rs1_addr_i = 5'd2; id_rd_en_i = 0; #1;
    chk("post_flush_raw", 32'(hazard_o), 32'd1);

    #2; rst_n = 0; #1;
    chk("async_rst_inflight", 32'(inflight_o), 32'd0);
    chk("async_rst_err", 32'(err_o), 32'd0);
    chk("async_rst_hazard", 32'(hazard_o), 32'd0);
    idle(); cyc();
    rst_n = 1;
    cyc();
    chk("after_rst_err", 32'(err_o), 32'd0);
    chk("after_rst_inflight", 32'(inflight_o), 32'd0);
    chk("after_rst_ready", 32'(id_ready_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
